// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter / timer. A start value is loaded, then counting is
// started, paused (stop) or resumed (start). Each expiry produces a
// one-cycle terminal-count pulse (tc). A non-reloading expiry also sets a
// sticky done flag. With reload_en=1 the counter reloads on expiry and keeps
// running, which makes it a periodic tick generator.
//
// Optional feature macro: COUNTDOWN_PRESCALE_EN
//   When defined, this adds parameter PRESCALE_W and input port prescale.
//   The counter then advances once every prescale+1 clk cycles while running.
//   When the macro is not defined, the counter advances on every clk cycle in
//   RUN.
//
// Ports:
//   clk        in   clock. All state updates on its rising edge.
//   rst        in   synchronous active-high reset.
//   load       in   load load_val into the reload register and the count.
//   load_val   in   [WIDTH] value captured on load.
//   start      in   begin or resume counting. In DONE, restart from the
//                   reload value.
//   stop       in   pause counting (count held).
//   reload_en  in   reload on expiry instead of finishing.
//   prescale   in   [PRESCALE_W] tick divider (only with the macro).
//   count      out  [WIDTH] current count (registered).
//   busy       out  1 while counting (RUN).
//   tc         out  terminal-count pulse, one cycle per expiry.
//   done       out  sticky expiry flag. Cleared by load, start or rst.
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH = 8
`ifdef COUNTDOWN_PRESCALE_EN
    , parameter int PRESCALE_W = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  reload_en,
`ifdef COUNTDOWN_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  tc,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [WIDTH-1:0]  count_q;
    logic [WIDTH-1:0]  reload_q;
    logic              busy_q;
    logic              tc_q;
    logic              done_q;
    logic              tick_s;
    logic [WIDTH-1:0]  count_dec_d;

`ifdef COUNTDOWN_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q;
    localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
`endif

    // Tick qualifier: the cycles in RUN on which the count may advance.
    always_comb begin
        tick_s      = 1'b0;
        count_dec_d = count_q - CNT_ONE;
        if (state_q == ST_RUN) begin
`ifdef COUNTDOWN_PRESCALE_EN
            tick_s = (presc_q == prescale);
`else
            tick_s = 1'b1;
`endif
        end else begin
            tick_s = 1'b0;
        end
    end

    // Control FSM with count, reload, flag and prescaler registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
            presc_q  <= PRESC_ZERO;
`endif
        end else begin
            // tc is a pulse. Only the expiry paths below raise it.
            tc_q <= 1'b0;
            if (load) begin
                // load aborts anything in progress and parks in IDLE
                reload_q <= load_val;
                count_q  <= load_val;
                state_q  <= ST_IDLE;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
                presc_q  <= PRESC_ZERO;
`endif
            end else if (stop) begin
                // stop beats start. It only has an effect while running.
                if (state_q == ST_RUN) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= state_q;
                end
`ifdef COUNTDOWN_PRESCALE_EN
                presc_q <= PRESC_ZERO;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (count_q != CNT_ZERO) begin
                                // resume from the held count, no decrement yet
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                                done_q  <= 1'b0;
                            end else begin
                                // a zero count expires at once
                                state_q <= ST_DONE;
                                tc_q    <= 1'b1;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
`ifdef COUNTDOWN_PRESCALE_EN
                            presc_q <= PRESC_ZERO;
`endif
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (tick_s) begin
`ifdef COUNTDOWN_PRESCALE_EN
                            presc_q <= PRESC_ZERO;
`endif
                            if (count_q == CNT_ONE) begin
                                tc_q <= 1'b1;
                                if (reload_en) begin
                                    count_q <= reload_q;
                                end else begin
                                    count_q <= CNT_ZERO;
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= ST_DONE;
                                end
                            end else if (count_q != CNT_ZERO) begin
                                count_q <= count_dec_d;
                            end else begin
                                // unreachable guard: never underflow below 0
                                count_q <= CNT_ZERO;
                            end
                        end else begin
`ifdef COUNTDOWN_PRESCALE_EN
                            presc_q <= presc_q + PRESC_ONE;
`endif
                            count_q <= count_q;
                        end
                    end
                    ST_DONE: begin
                        if (start) begin
                            count_q <= reload_q;
                            if (reload_q != CNT_ZERO) begin
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                                done_q  <= 1'b0;
                            end else begin
                                // a zero reload value expires again immediately
                                tc_q   <= 1'b1;
                                done_q <= 1'b1;
                            end
`ifdef COUNTDOWN_PRESCALE_EN
                            presc_q <= PRESC_ZERO;
`endif
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (default build).
module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       stop;
    logic       reload_en;
    logic [7:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    int errors;
    int checks;

    countdown_timer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .stop      (stop),
        .reload_en (reload_en),
        .count     (count),
        .busy      (busy),
        .tc        (tc),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle before sampling / driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; load_val = 8'hAA; start = 1'b1; stop = 1'b0; reload_en = 1'b0;
        step();
        step();
        checks++;
        if ({count, busy, tc, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_held: count=%0d busy=%b tc=%b done=%b, want 0 0 0 0", count, busy, tc, done);
        end
        rst = 1'b0; load = 1'b0; start = 1'b0;
        step();
        // start was 0 after release, count 0 in IDLE stays put
        checks++;
        if ({count, busy, tc, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: count=%0d busy=%b tc=%b done=%b, want 0 0 0 0", count, busy, tc, done);
        end
    endtask

    task automatic test_oneshot();
        load_val = 8'd3; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if ({count, busy, done} !== {8'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL oneshot_load: count=%0d busy=%b done=%b, want 3 0 0", count, busy, done);
        end
        start = 1'b1;
        step();  // E0
        start = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) step();
            checks++;
            if ({count, busy, tc, done} !== {8'(3 - i), (i != 3), (i == 3), (i == 3)}) begin
                errors++;
                $display("FAIL oneshot_e%0d: count=%0d busy=%b tc=%b done=%b, want %0d %b %b %b",
                         i, count, busy, tc, done, 3 - i, (i != 3), (i == 3), (i == 3));
            end
        end
        step();
        checks++;
        if ({count, busy, tc, done} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL oneshot_after: count=%0d busy=%b tc=%b done=%b, want 0 0 0 1", count, busy, tc, done);
        end
    endtask

    task automatic test_autoreload();
        load_val = 8'd2; load = 1'b1; reload_en = 1'b1;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({count, busy, tc} !== {8'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL auto_start: count=%0d busy=%b tc=%b, want 2 1 0", count, busy, tc);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if ({count, busy, tc, done} !== {((i % 2) == 1) ? 8'd1 : 8'd2, 1'b1, ((i % 2) == 0), 1'b0}) begin
                errors++;
                $display("FAIL auto_tick%0d: count=%0d busy=%b tc=%b done=%b, want %0d 1 %b 0",
                         i, count, busy, tc, done, ((i % 2) == 1) ? 1 : 2, ((i % 2) == 0));
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++;
            if ({count, busy, tc, done} !== {8'd2, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL auto_stopped%0d: count=%0d busy=%b tc=%b done=%b, want 2 0 0 0", i, count, busy, tc, done);
            end
        end
        reload_en = 1'b0;
    endtask

    task automatic test_pause_resume();
        load_val = 8'd5; load = 1'b1;
        step();
        load = 1'b0; start = 1'b1;
        step();  // count 5
        start = 1'b0;
        step();  // 4
        step();  // 3
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({count, busy} !== {8'd3, 1'b0}) begin
            errors++;
            $display("FAIL pause_hold: count=%0d busy=%b, want 3 0", count, busy);
        end
        start = 1'b1; stop = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        checks++;
        if ({count, busy, tc} !== {8'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL pause_stop_wins: count=%0d busy=%b tc=%b, want 3 0 0", count, busy, tc);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({count, busy} !== {8'd3, 1'b1}) begin
            errors++;
            $display("FAIL resume_start: count=%0d busy=%b, want 3 1", count, busy);
        end
        step();
        step();
        checks++;
        if ({count, tc} !== {8'd1, 1'b0}) begin
            errors++;
            $display("FAIL resume_mid: count=%0d tc=%b, want 1 0", count, tc);
        end
        step();
        checks++;
        if ({count, busy, tc, done} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL resume_expire: count=%0d busy=%b tc=%b done=%b, want 0 0 1 1", count, busy, tc, done);
        end
    endtask

    task automatic test_boundaries();
        // zero load expires immediately
        load_val = 8'd0; load = 1'b1;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({count, busy, tc, done} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL zero_start: count=%0d busy=%b tc=%b done=%b, want 0 0 1 1", count, busy, tc, done);
        end
        step();
        checks++;
        if ({busy, tc, done} !== {1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL zero_after: busy=%b tc=%b done=%b, want 0 0 1", busy, tc, done);
        end
        // start in DONE with zero reload value fires again
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({count, busy, tc, done} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL zero_restart: count=%0d busy=%b tc=%b done=%b, want 0 0 1 1", count, busy, tc, done);
        end
        // load during RUN
        load_val = 8'd9; load = 1'b1;
        step();
        load = 1'b0; start = 1'b1;
        step();  // 9
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();  // 4
        checks++;
        if ({count, busy} !== {8'd4, 1'b1}) begin
            errors++;
            $display("FAIL load_run_pre: count=%0d busy=%b, want 4 1", count, busy);
        end
        load_val = 8'd7; load = 1'b1;
        step();
        load = 1'b0;
        step();
        checks++;
        if ({count, busy, tc, done} !== {8'd7, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_run: count=%0d busy=%b tc=%b done=%b, want 7 0 0 0", count, busy, tc, done);
        end
        // reset mid-run
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({count, busy, tc, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_run: count=%0d busy=%b tc=%b done=%b, want 0 0 0 0", count, busy, tc, done);
        end
        step();
        checks++;
        if ({count, busy, tc, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_after: count=%0d busy=%b tc=%b done=%b, want 0 0 0 0", count, busy, tc, done);
        end
    endtask

    task automatic test_back_to_back();
        load_val = 8'd2; load = 1'b1;
        step();
        load = 1'b0; start = 1'b1;
        step();  // 2
        start = 1'b0;
        step();  // 1
        step();  // 0, tc
        checks++;
        if ({count, tc, done} !== {8'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: count=%0d tc=%b done=%b, want 0 1 1", count, tc, done);
        end
        // restart from DONE reloads the value and runs again, with reload_en on
        start = 1'b1; reload_en = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({count, busy, tc, done} !== {8'd2, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_restart: count=%0d busy=%b tc=%b done=%b, want 2 1 0 0", count, busy, tc, done);
        end
        step();  // 1
        step();  // reload to 2, tc
        checks++;
        if ({count, busy, tc, done} !== {8'd2, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_reload: count=%0d busy=%b tc=%b done=%b, want 2 1 1 0", count, busy, tc, done);
        end
        reload_en = 1'b0;
        step();  // 1
        step();  // expires without reload
        checks++;
        if ({count, busy, tc, done} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_final: count=%0d busy=%b tc=%b done=%b, want 0 0 1 1", count, busy, tc, done);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; load = 1'b0; load_val = 8'd0; start = 1'b0; stop = 1'b0; reload_en = 1'b0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause_resume();
        test_boundaries();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
